sw_pass_scheduler: RTL and testbench

SW_PASS_SCHEDULER -- requirements
Module: sw_pass_scheduler

---
 rtl/sw_pass_scheduler.sv | 148 ++++++++++++++
 tb/tb_sw_pass_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pass_scheduler.sv
// sw_pass_scheduler: runs seg passes of a T stream through a PE array.
// Pass 0 sources T from upstream; each later pass replays the previous pass's results from the feedback buffer.
module sw_pass_scheduler #(
    parameter int PE_ARRAY_SIZE = 64,
    parameter int VEF_BIT       = 16,
    parameter int ADDR_BIT      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_BIT:0]  i_t_len,
    input  logic [7:0]         i_seg_num,
    output logic               o_busy,
    output logic               o_done,
    output logic [VEF_BIT-1:0] o_max,
    input  logic               i_t_valid,
    input  logic [1:0]         i_t,
    output logic               o_t_ready,
    output logic               o_s_req,
    input  logic               i_s_ack,
    output logic               o_pe_valid,
    output logic [1:0]         o_pe_t,
    output logic [VEF_BIT-1:0] o_pe_v,
    output logic [VEF_BIT-1:0] o_pe_f,
    output logic               o_pe_newline,
    output logic               o_pe_lock,
    input  logic               i_pe_valid,
    input  logic [1:0]         i_pe_t,
    input  logic [VEF_BIT-1:0] i_pe_v,
    input  logic [VEF_BIT-1:0] i_pe_f
);

    localparam int EW    = 2 + 2 * VEF_BIT;
    localparam int DEPTH = 1 << ADDR_BIT;
    localparam logic [ADDR_BIT:0] DEPTH_L = {1'b1, {ADDR_BIT{1'b0}}};

    if (PE_ARRAY_SIZE < 1) begin : g_bad_size
        $error("PE_ARRAY_SIZE must be positive");
    end

    typedef enum logic [2:0] {IDLE, SREQ, FEED, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_BIT:0]  len_q, len_d, sent_q, sent_d, ret_q, ret_d;
    logic [ADDR_BIT:0]  len_in, sent_inc;
    logic [7:0]         seg_q, seg_d, pass_q, pass_d;
    logic [8:0]         pass_inc;
    logic [VEF_BIT-1:0] max_q, max_d, pe_v_q, pe_v_d, pe_f_q, pe_f_d;
    logic [1:0]         pe_t_q, pe_t_d;
    logic               pe_valid_q, pe_valid_d, pe_newline_q, pe_newline_d, pe_lock_q, pe_lock_d;
    logic               take, issue, mem_we;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      rd;

    assign len_in   = (i_t_len > DEPTH_L) ? DEPTH_L : i_t_len;
    assign sent_inc = sent_q + 1'b1;
    assign pass_inc = {1'b0, pass_q} + 9'd1;
    assign rd       = mem_q[sent_q[ADDR_BIT-1:0]];
    assign take     = (state_q == FEED || state_q == DRAIN) && i_pe_valid && ret_q < len_q;
    assign issue    = state_q == FEED && (pass_q != 8'd0 || i_t_valid);
    // The last pass's results only feed o_max; nothing will read them back.
    assign mem_we   = take && pass_inc != {1'b0, seg_q};

    assign o_busy       = state_q != IDLE;
    assign o_done       = state_q == DONE;
    assign o_s_req      = state_q == SREQ;
    assign o_t_ready    = state_q == FEED && pass_q == 8'd0;
    assign o_max        = max_q;
    assign o_pe_valid   = pe_valid_q;
    assign o_pe_t       = pe_t_q;
    assign o_pe_v       = pe_v_q;
    assign o_pe_f       = pe_f_q;
    assign o_pe_newline = pe_newline_q;
    assign o_pe_lock    = pe_lock_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        seg_d        = seg_q;
        pass_d       = pass_q;
        sent_d       = issue ? sent_inc : sent_q;
        ret_d        = take ? ret_q + 1'b1 : ret_q;
        max_d        = (take && i_pe_v > max_q) ? i_pe_v : max_q;
        pe_valid_d   = issue;
        pe_lock_d    = state_q == FEED && !issue;
        pe_newline_d = issue && sent_q == '0;
        {pe_t_d, pe_v_d, pe_f_d} = !issue ? '0 : (pass_q == 8'd0) ? {i_t, {(2 * VEF_BIT){1'b0}}} : rd;
        case (state_q)
            IDLE: if (i_start) begin
                len_d   = len_in;
                seg_d   = i_seg_num;
                max_d   = '0;
                pass_d  = '0;
                sent_d  = '0;
                ret_d   = '0;
                state_d = (len_in == '0 || i_seg_num == 8'd0) ? DONE : SREQ;
            end
            SREQ: state_d = i_s_ack ? FEED : SREQ;
            FEED: state_d = (issue && sent_inc == len_q) ? DRAIN : FEED;
            DRAIN: if (ret_q == len_q) begin
                pass_d  = pass_q + 8'd1;
                sent_d  = '0;
                ret_d   = '0;
                state_d = (pass_inc < {1'b0, seg_q}) ? SREQ : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            seg_q        <= '0;
            pass_q       <= '0;
            sent_q       <= '0;
            ret_q        <= '0;
            max_q        <= '0;
            pe_valid_q   <= 1'b0;
            pe_t_q       <= '0;
            pe_v_q       <= '0;
            pe_f_q       <= '0;
            pe_newline_q <= 1'b0;
            pe_lock_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            seg_q        <= seg_d;
            pass_q       <= pass_d;
            sent_q       <= sent_d;
            ret_q        <= ret_d;
            max_q        <= max_d;
            pe_valid_q   <= pe_valid_d;
            pe_t_q       <= pe_t_d;
            pe_v_q       <= pe_v_d;
            pe_f_q       <= pe_f_d;
            pe_newline_q <= pe_newline_d;
            pe_lock_q    <= pe_lock_d;
        end
    end

    // Reads of pass k+1 start only after pass k fully drained, so no collision handling is needed.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ret_q[ADDR_BIT-1:0]] <= {i_pe_t, i_pe_v, i_pe_f};
    end

endmodule

// File: tb/tb_sw_pass_scheduler.sv
// tb_sw_pass_scheduler: directed jobs against a queue-based model of the pass schedule and a latency-3 PE array.
module tb_sw_pass_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, i_start, i_t_valid, i_s_ack, i_pe_valid;
    logic [8:0]  i_t_len;
    logic [7:0]  i_seg_num;
    logic [1:0]  i_t, i_pe_t;
    logic [15:0] i_pe_v, i_pe_f;
    logic        o_busy, o_done, o_t_ready, o_s_req, o_pe_valid, o_pe_newline, o_pe_lock;
    logic [15:0] o_max, o_pe_v, o_pe_f;
    logic [1:0]  o_pe_t;

    sw_pass_scheduler #(.PE_ARRAY_SIZE(64), .VEF_BIT(16), .ADDR_BIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_t_len(i_t_len), .i_seg_num(i_seg_num),
        .o_busy(o_busy), .o_done(o_done), .o_max(o_max),
        .i_t_valid(i_t_valid), .i_t(i_t), .o_t_ready(o_t_ready),
        .o_s_req(o_s_req), .i_s_ack(i_s_ack),
        .o_pe_valid(o_pe_valid), .o_pe_t(o_pe_t), .o_pe_v(o_pe_v), .o_pe_f(o_pe_f),
        .o_pe_newline(o_pe_newline), .o_pe_lock(o_pe_lock),
        .i_pe_valid(i_pe_valid), .i_pe_t(i_pe_t), .i_pe_v(i_pe_v), .i_pe_f(i_pe_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [1:0]  t;
        logic [15:0] v;
        logic [15:0] f;
    } ret_t;

    int checks = 0, errs = 0, cyc = 0;
    logic [33:0] exp0[$];
    logic [33:0] nxt[$];
    ret_t        rq[$];
    int          mlen = 1, mseg = 0, mode = 0, lat = 3;
    int          issued = 0, nl_cnt = 0, lock_cnt = 0, sreq_cnt = 0, done_cnt = 0, mret = 0;
    logic [15:0] mmax = 16'd0;
    bit          mon = 1'b0, junk_en = 1'b0, junk_now = 1'b0;
    logic [1:0]  t_list [0:299];
    int          t_n = 0, t_idx = 0, gap_at = -1, gap_left = 0, ack_wait = 0;
    logic [15:0] iss_v [0:1023];
    bit          p_ready = 1'b0, p_tv = 1'b0, p_sreq = 1'b0, p_ack = 1'b0;
    logic [1:0]  p_t = 2'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] tabv(input int k);
        case (k % 4)
            0: return 16'd5;
            1: return 16'd9;
            2: return 16'd2;
            default: return 16'd7;
        endcase
    endfunction

    // Per-cycle: account for the edge just taken, check outputs, then drive the environment.
    initial begin
        logic [33:0] e;
        ret_t        r;
        int          p, pos;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (p_sreq && p_ack) sreq_cnt++;
            if (p_ready && p_tv) begin
                exp0.push_back({p_t, 32'h0});
                t_idx++;
            end
            chk("pe_lock", 64'(o_pe_lock), 64'(p_ready && !p_tv));
            if (p_ready) chk("pass0_valid", 64'(o_pe_valid), 64'(p_tv));
            if (o_pe_valid) begin
                if (mlen == 0) begin
                    chk("issue_on_empty_job", 64'(o_pe_valid), 64'd0);
                end else begin
                    p   = issued / mlen;
                    pos = issued % mlen;
                    if ((p == 0 ? exp0.size() : nxt.size()) == 0) begin
                        chk("extra_issue", 64'(issued), 64'(mlen * mseg));
                    end else begin
                        e = (p == 0) ? exp0.pop_front() : nxt.pop_front();
                        chk("pe_data", 64'({o_pe_t, o_pe_v, o_pe_f}), 64'(e));
                    end
                    chk("newline", 64'(o_pe_newline), 64'(pos == 0));
                    if (issued < 1024) iss_v[issued] = o_pe_v;
                    r.due = cyc + lat - 1;
                    r.t   = o_pe_t;
                    r.v   = (mode == 0) ? tabv(pos) : o_pe_v + 16'd1;
                    r.f   = o_pe_v;
                    rq.push_back(r);
                    issued++;
                end
            end else begin
                chk("newline_idle", 64'(o_pe_newline), 64'd0);
            end
            if (o_pe_lock) lock_cnt++;
            if (o_pe_newline) nl_cnt++;
            if (mon) chk("o_max_run", 64'(o_max), 64'(mmax));
            if (o_done) begin
                done_cnt++;
                mon = 1'b0;
            end
            i_pe_valid = 1'b0;
            i_pe_t     = 2'd0;
            i_pe_v     = 16'd0;
            i_pe_f     = 16'd0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                i_pe_valid = 1'b1;
                i_pe_t     = r.t;
                i_pe_v     = r.v;
                i_pe_f     = r.f;
                if (mret / mlen + 1 < mseg) nxt.push_back({r.t, r.v, r.f});
                if (r.v > mmax) mmax = r.v;
                mret++;
                junk_now = junk_en && (mret % mlen == 0);
            end else if (junk_now) begin
                // Stray result after a pass completed: must not be counted or stored.
                i_pe_valid = 1'b1;
                i_pe_t     = 2'd3;
                i_pe_v     = 16'hFFFF;
                i_pe_f     = 16'hFFFF;
                junk_now   = 1'b0;
            end
            if (o_s_req) begin
                ack_wait++;
                i_s_ack = ack_wait >= 2;
            end else begin
                ack_wait = 0;
                i_s_ack  = 1'b0;
            end
            if (t_idx == gap_at && gap_left > 0) begin
                i_t_valid = 1'b0;
                gap_left--;
            end else begin
                i_t_valid = t_idx < t_n;
                i_t       = (t_idx < t_n) ? t_list[t_idx] : 2'd0;
            end
            p_ready = o_t_ready;
            p_tv    = i_t_valid;
            p_t     = i_t;
            p_sreq  = o_s_req;
            p_ack   = i_s_ack;
        end
    end

    task automatic flush_model();
        exp0.delete();
        nxt.delete();
        rq.delete();
        issued   = 0;
        mret     = 0;
        nl_cnt   = 0;
        lock_cnt = 0;
        sreq_cnt = 0;
        t_idx    = 0;
        junk_now = 1'b0;
    endtask

    task automatic start_job(input int tlen, input int seg, input int md, input bit junk);
        @(negedge clk);
        flush_model();
        mlen      = (tlen > 256) ? 256 : tlen;
        mseg      = seg;
        mode      = md;
        junk_en   = junk;
        mmax      = 16'd0;
        mon       = 1'b1;
        i_t_len   = 9'(tlen);
        i_seg_num = 8'(seg);
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
    endtask

    task automatic finish_job(input int d0);
        int expn;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        #2;
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (3) @(negedge clk);
        expn = (mlen > 0 && mseg > 0) ? mseg : 0;
        chk("done_once", 64'(done_cnt), 64'(d0 + 1));
        chk("idle_after_done", 64'(o_busy), 64'd0);
        chk("issued_total", 64'(issued), 64'(mlen * mseg));
        chk("sreq_count", 64'(sreq_cnt), 64'(expn));
        chk("newline_count", 64'(nl_cnt), 64'(expn));
        chk("pending_expect", 64'(exp0.size() + nxt.size()), 64'd0);
        chk("o_max_final", 64'(o_max), 64'(mmax));
    endtask

    task automatic load_t(input int n, input int kind);
        for (int i = 0; i < n; i++) t_list[i] = (kind == 0) ? 2'(i) : 2'((i * 7 + i / 5 + kind) % 4);
        t_n      = n;
        gap_at   = -1;
        gap_left = 0;
    endtask

    initial begin
        int d0;
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_t_len    = 9'd0;
        i_seg_num  = 8'd0;
        i_t_valid  = 1'b0;
        i_t        = 2'd0;
        i_s_ack    = 1'b0;
        i_pe_valid = 1'b0;
        i_pe_t     = 2'd0;
        i_pe_v     = 16'd0;
        i_pe_f     = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({o_busy, o_done, o_s_req, o_t_ready, o_pe_valid, o_pe_newline, o_pe_lock, o_pe_t, o_pe_v, o_pe_f, o_max}), 64'd0);
        rst_n = 1'b1;

        load_t(4, 0);
        d0 = done_cnt;
        start_job(4, 1, 0, 1'b1);
        finish_job(d0);
        chk("t1_max_literal", 64'(o_max), 64'd9);
        chk("t1_newline_literal", 64'(nl_cnt), 64'd1);

        load_t(3, 1);
        d0 = done_cnt;
        start_job(3, 3, 1, 1'b1);
        finish_job(d0);
        chk("t2_max_literal", 64'(o_max), 64'd3);
        chk("t2_sreq_literal", 64'(sreq_cnt), 64'd3);
        for (int i = 3; i < 9; i++) chk("t2_pass_v_literal", 64'(iss_v[i]), (i < 6) ? 64'd1 : 64'd2);

        load_t(6, 2);
        gap_at   = 2;
        gap_left = 2;
        d0 = done_cnt;
        start_job(6, 2, 1, 1'b0);
        finish_job(d0);
        chk("t3_lock_literal", 64'(lock_cnt), 64'd2);

        load_t(0, 0);
        d0 = done_cnt;
        start_job(0, 3, 1, 1'b0);
        chk("t5_done_next_cycle", 64'(o_done), 64'd1);
        chk("t5_max_zero", 64'(o_max), 64'd0);
        finish_job(d0);
        d0 = done_cnt;
        start_job(4, 0, 1, 1'b0);
        chk("t5_seg0_done", 64'(o_done), 64'd1);
        finish_job(d0);

        load_t(300, 3);
        d0 = done_cnt;
        start_job(300, 2, 1, 1'b0);
        finish_job(d0);
        chk("t4_clamp_literal", 64'(issued), 64'd512);

        load_t(3, 1);
        d0 = done_cnt;
        start_job(3, 1, 1, 1'b0);
        repeat (4) @(negedge clk);
        i_t_len   = 9'd0;
        i_seg_num = 8'd5;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        finish_job(d0);
        chk("t6_ignored_start_issued", 64'(issued), 64'd3);

        load_t(3, 2);
        d0 = done_cnt;
        start_job(3, 3, 1, 1'b0);
        for (int i = 0; i < 500 && issued < 6; i++) @(posedge clk);
        #2;
        chk("t7_reach_pass1_drain", 64'(issued), 64'd6);
        @(negedge clk);
        rst_n = 1'b0;
        mon   = 1'b0;
        flush_model();
        #1;
        chk("t7_async_reset_outputs", 64'({o_busy, o_done, o_s_req, o_t_ready, o_pe_valid, o_pe_newline, o_pe_lock, o_pe_t, o_pe_v, o_pe_f, o_max}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_t(4, 0);
        d0 = done_cnt;
        start_job(4, 2, 0, 1'b1);
        finish_job(d0);
        chk("t7_after_reset_max", 64'(o_max), 64'd9);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end

endmodule
